fifo_write_adapter: RTL and testbench
=====================================

// Module: fifo_write_adapter
// PURPOSE
//  Write-side ingress stage in front of async_fifo, clocked in the write_clk domain.
//  Converts an upstream valid/ready stream into async_fifo write_en/write_data strobes
//  through a 2-entry skid buffer, so upstream never sees a combinational path from full.
//  Throttles early on fifo_count and reports word and flush statistics.
// PARAMETERS
//  DATA_WIDTH  8  width of a data word
//  DEPTH       8  depth of the downstream async_fifo; power of two
//  AF_THRESH   6  fifo_count level at or above which new input is refused; 1..DEPTH
//  CNT_WIDTH  16  width of accepted_cnt and dropped_cnt
// PORTS
//  write_clk        in   1                 write-domain clock
//  write_reset_n    in   1                 asynchronous, active-low reset
//  flush            in   1                 synchronous discard of all held words
//  in_valid         in   1                 upstream word valid
//  in_ready         out  1                 upstream may transfer (registered)
//  in_data          in   DATA_WIDTH        upstream word
//  fifo_full        in   1                 async_fifo full
//  fifo_count       in   clog2(DEPTH)+1    async_fifo write-domain occupancy
//  fifo_write_en    out  1                 async_fifo write_en
//  fifo_write_data  out  DATA_WIDTH        async_fifo write_data
//  accepted_cnt     out  CNT_WIDTH         words written into the FIFO; wraps
//  dropped_cnt      out  CNT_WIDTH         words discarded by flush; saturates
// BEHAVIOUR
//  Reset values:
//   - in_ready=0, occupancy=EMPTY, fifo_write_en=0, fifo_write_data=0.
//   - accepted_cnt=0, dropped_cnt=0.
//   - in_ready rises on the first write_clk edge after release.
//  Handshakes:
//   - push = in_valid & in_ready.
//   - pop = fifo_write_en = (occ!=EMPTY) & !fifo_full. This is combinational, and
//     fifo_write_data = head word.
//   - The FIFO takes the word on the edge where fifo_write_en=1.
//  Latency:
//   - A word pushed at edge N is driven on fifo_write_en in the cycle after edge N,
//     when fifo_full=0.
//   - Sustained throughput is 1 word per clock.
//  Occupancy FSM (head register H, skid register S):
//   - EMPTY --push--> ONE (H = in_data).
//   - ONE --push & !pop--> TWO (S = in_data).
//   - ONE --pop & !push--> EMPTY.
//   - ONE --push & pop--> ONE (H = in_data).
//   - TWO --pop--> ONE (H = S). A push cannot occur in TWO.
//   - Order is strictly FIFO. S is never driven out ahead of H.
//  in_ready is a register:
//   - next value = (occ_next != TWO) & (fifo_count < AF_THRESH) & !flush.
//   - Because fifo_count lags by one cycle, the skid entry absorbs the one in-flight word.
//   - No word is ever lost or duplicated.
//  flush (highest priority):
//   - Forces occ = EMPTY next cycle and ignores push that cycle.
//   - fifo_write_en is forced 0 while flush=1.
//   - dropped_cnt += words held (0, 1 or 2), saturating at all-ones.
//   - accepted_cnt is not altered.
//  accepted_cnt:
//   - +1 on each fifo_write_en=1 cycle, modulo 2^CNT_WIDTH.
//  fifo_full:
//   - While asserted, H and S hold and fifo_write_en=0. fifo_write_data stays stable.
//  Reset asserted mid-operation:
//   - All state returns to reset values asynchronously. Held words are discarded.
//   - dropped_cnt is not incremented for words lost to reset.
// TESTING
//  1. Reset, then release -> all outputs 0 during reset; in_ready=1 one edge after release.
//  2. Stream 0x00..0x77 with in_valid=1 and fifo_full=0 -> fifo_write_en=1 for 8
//     consecutive cycles; data in order; accepted_cnt=8.
//  3. Push 0x11 then 0x22 with fifo_full=1 -> occ=TWO, in_ready=0; on fifo_full=0,
//     0x11 then 0x22 are written on consecutive edges.
//  4. fifo_count=6 with AF_THRESH=6 -> in_ready=0 next edge; fifo_count=5 -> in_ready=1
//     next edge; no word dropped.
//  5. Two words held, fifo_full=1, pulse flush -> occ=EMPTY; dropped_cnt=2; no
//     fifo_write_en; the next pushed 0xA5 is the next word written.
//  6. CNT_WIDTH=4: write 17 words -> accepted_cnt=1. Assert write_reset_n=0 with TWO
//     held -> immediate clear, no write.

Source files
------------

// File: rtl/fifo_write_adapter.sv
// fifo_write_adapter
// Write-side ingress stage placed in front of async_fifo, in the write_clk domain.
// It turns an upstream valid/ready stream into async_fifo write strobes through a
// two-entry skid buffer. in_ready is a flop, so upstream never sees a path from
// fifo_full. New input is refused early once fifo_count reaches AF_THRESH. The
// block also keeps a wrapping count of written words and a saturating count of
// words discarded by flush.
module fifo_write_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    write_clk,
  input  logic                    write_reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    fifo_full,
  input  logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    fifo_write_en,
  output logic [DATA_WIDTH-1:0]   fifo_write_data,
  output logic [CNT_WIDTH-1:0]    accepted_cnt,
  output logic [CNT_WIDTH-1:0]    dropped_cnt
);

  localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;
  // AF_THRESH never exceeds DEPTH, so it always fits the occupancy width.
  localparam logic [COUNT_WIDTH-1:0] AF_LEVEL = COUNT_WIDTH'(AF_THRESH);

  // Number of words currently held. H is always the older word; S is used only
  // when both registers are full.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0]  accepted_q, accepted_d;
  logic [CNT_WIDTH-1:0]  dropped_q, dropped_d;

  logic                  push;
  logic                  pop;
  logic [1:0]            held_words;
  logic [CNT_WIDTH:0]    dropped_sum;

  // Handshakes. A flush cycle suppresses both the push and the pop.
  always_comb begin
    push = in_valid & in_ready_q & ~flush;
    pop  = (occ_q != OCC_EMPTY) & ~fifo_full & ~flush;
  end

  // Occupancy FSM and data movement. Order is kept strictly FIFO: S only ever
  // moves into H and is never presented to the FIFO directly.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            occ_d  = OCC_ONE;
            head_d = in_data;
          end
        end
        OCC_ONE: begin
          if (push && !pop) begin
            occ_d  = OCC_TWO;
            skid_d = in_data;
          end else if (pop && !push) begin
            occ_d = OCC_EMPTY;
          end else if (push && pop) begin
            head_d = in_data;
          end
        end
        OCC_TWO: begin
          // in_ready is low whenever the buffer is full, so no push here.
          if (pop) begin
            occ_d  = OCC_ONE;
            head_d = skid_q;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  // Next in_ready. fifo_count lags the real occupancy by a cycle; the skid entry
  // absorbs the single word that can still arrive after the threshold is hit.
  always_comb begin
    in_ready_d = (occ_d != OCC_TWO) & (fifo_count < AF_LEVEL) & ~flush;
  end

  // Statistics: accepted wraps, dropped saturates at all-ones.
  always_comb begin
    case (occ_q)
      OCC_ONE: held_words = 2'd1;
      OCC_TWO: held_words = 2'd2;
      default: held_words = 2'd0;
    endcase
    dropped_sum = {1'b0, dropped_q} + (CNT_WIDTH+1)'(held_words);
    accepted_d  = pop ? accepted_q + 1'b1 : accepted_q;
    dropped_d   = dropped_q;
    if (flush) begin
      dropped_d = dropped_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : dropped_sum[CNT_WIDTH-1:0];
    end
  end

  // State registers. Reset discards held words without counting them as dropped.
  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      occ_q      <= OCC_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      accepted_q <= '0;
      dropped_q  <= '0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      accepted_q <= accepted_d;
      dropped_q  <= dropped_d;
    end
  end

  // Output mapping. The write strobe is combinational from fifo_full.
  always_comb begin
    in_ready        = in_ready_q;
    fifo_write_en   = pop;
    fifo_write_data = head_q;
    accepted_cnt    = accepted_q;
    dropped_cnt     = dropped_q;
  end

endmodule

// File: tb/tb_fifo_write_adapter.sv
// Bench for fifo_write_adapter, built with a 4-bit counter width so that both
// wrap and saturation are reachable in a short run.
module tb_fifo_write_adapter;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int CW    = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          fifo_full;
  logic [3:0]    fifo_count;
  logic          fifo_write_en;
  logic [DW-1:0] fifo_write_data;
  logic [CW-1:0] accepted_cnt;
  logic [CW-1:0] dropped_cnt;

  int errors;
  int checks;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;

  fifo_write_adapter #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AF_THRESH(AF),
    .CNT_WIDTH(CW)
  ) dut (
    .write_clk(clk),
    .write_reset_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .fifo_full(fifo_full),
    .fifo_count(fifo_count),
    .fifo_write_en(fifo_write_en),
    .fifo_write_data(fifo_write_data),
    .accepted_cnt(accepted_cnt),
    .dropped_cnt(dropped_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: accepted words are queued at the push edge and compared when the
  // FIFO takes a word. Flush empties the queue; writes during flush are errors.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        checks++;
        if (fifo_write_en !== 1'b0) begin
          errors++;
          $display("FAIL flush_wen: got %b required 0", fifo_write_en);
        end
        exp_q.delete();
      end else begin
        if (fifo_write_en === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: write of %h with nothing expected", fifo_write_data);
          end else begin
            exp_word = exp_q.pop_front();
            if (fifo_write_data !== exp_word) begin
              errors++;
              $display("FAIL sb_data: got %h required %h", fifo_write_data, exp_word);
            end else begin
              $display("write %h ok", fifo_write_data);
            end
          end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(in_data);
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    fifo_full = 1'b0; fifo_count = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", in_ready); end
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b required 0", fifo_write_en); end
    checks++; if (fifo_write_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h required 00", fifo_write_data); end
    checks++; if (accepted_cnt !== 4'd0) begin errors++; $display("FAIL rst_acc: got %0d required 0", accepted_cnt); end
    checks++; if (dropped_cnt !== 4'd0) begin errors++; $display("FAIL rst_drop: got %0d required 0", dropped_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_ready0: got %b required 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready1: got %b required 1", in_ready); end
    $display("reset done");
  endtask

  task automatic test_stream(input int n, input logic [DW-1:0] step, input logic [CW-1:0] exp_acc);
    logic [DW-1:0] d;
    fifo_full = 1'b0;
    in_valid  = 1'b1;
    d = '0;
    in_data = d;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_write_en !== 1'b1 || fifo_write_data !== d) begin
        errors++;
        $display("FAIL stream_word[%0d]: got en=%b data=%h required en=1 data=%h", i, fifo_write_en, fifo_write_data, d);
      end
      d = d + step;
      if (i < n) in_data = d;
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL stream_idle: got %b required 0", fifo_write_en); end
    checks++; if (accepted_cnt !== exp_acc) begin errors++; $display("FAIL stream_acc: got %0d required %0d", accepted_cnt, exp_acc); end
    $display("stream of %0d words done", n);
  endtask

  task automatic test_full_skid;
    fifo_full = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL skid_wen_full: got %b required 0", fifo_write_en); end
    in_data = 8'h22;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready: got %b required 0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b0 || fifo_write_data !== 8'h11) begin errors++; $display("FAIL skid_hold: got en=%b data=%h required en=0 data=11", fifo_write_en, fifo_write_data); end
    fifo_full = 1'b0;
    #1;
    checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 8'h11) begin errors++; $display("FAIL skid_first: got en=%b data=%h required en=1 data=11", fifo_write_en, fifo_write_data); end
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 8'h22) begin errors++; $display("FAIL skid_second: got en=%b data=%h required en=1 data=22", fifo_write_en, fifo_write_data); end
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_drain: got en=%b ready=%b required en=0 ready=1", fifo_write_en, in_ready); end
    $display("skid test done");
  endtask

  task automatic test_threshold;
    fifo_count = 4'd6;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL af_ready_low: got %b required 0", in_ready); end
    in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || fifo_write_en !== 1'b0) begin errors++; $display("FAIL af_hold: got ready=%b en=%b required 0 0", in_ready, fifo_write_en); end
    fifo_count = 4'd5;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL af_ready_high: got %b required 1", in_ready); end
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 8'h5A) begin errors++; $display("FAIL af_word: got en=%b data=%h required en=1 data=5a", fifo_write_en, fifo_write_data); end
    in_valid = 1'b0; fifo_count = 4'd0;
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b0 || dropped_cnt !== 4'd0) begin errors++; $display("FAIL af_after: got en=%b dropped=%0d required 0 0", fifo_write_en, dropped_cnt); end
    $display("threshold test done");
  endtask

  task automatic test_flush;
    logic [CW-1:0] acc_before;
    acc_before = accepted_cnt;
    fifo_full = 1'b1; in_valid = 1'b1; in_data = 8'hC1;
    @(negedge clk);
    in_data = 8'hC2;
    @(negedge clk);
    in_data = 8'hEE;
    flush = 1'b1;
    #1;
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL flush_full_wen: got %b required 0", fifo_write_en); end
    fifo_full = 1'b0;
    #1;
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL flush_force_wen: got %b required 0", fifo_write_en); end
    @(negedge clk);
    flush = 1'b0; in_data = 8'hA5;
    checks++; if (dropped_cnt !== 4'd2) begin errors++; $display("FAIL flush_dropped: got %0d required 2", dropped_cnt); end
    checks++; if (in_ready !== 1'b0 || fifo_write_en !== 1'b0) begin errors++; $display("FAIL flush_empty: got ready=%b en=%b required 0 0", in_ready, fifo_write_en); end
    checks++; if (accepted_cnt !== acc_before) begin errors++; $display("FAIL flush_acc: got %0d required %0d", accepted_cnt, acc_before); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || fifo_write_en !== 1'b0) begin errors++; $display("FAIL flush_recover: got ready=%b en=%b required 1 0", in_ready, fifo_write_en); end
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 8'hA5) begin errors++; $display("FAIL flush_next: got en=%b data=%h required en=1 data=a5", fifo_write_en, fifo_write_data); end
    in_valid = 1'b0;
    @(negedge clk);
    $display("flush test done");
  endtask

  task automatic test_reset_midop;
    fifo_full = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_data = 8'h3D;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_two: got ready=%b required 0", in_ready); end
    #2;
    rst_n = 1'b0; fifo_full = 1'b0;
    #1;
    checks++; if (fifo_write_en !== 1'b0 || fifo_write_data !== 8'h00) begin errors++; $display("FAIL mid_clear: got en=%b data=%h required en=0 data=00", fifo_write_en, fifo_write_data); end
    checks++; if (accepted_cnt !== 4'd0 || dropped_cnt !== 4'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_cnts: got acc=%0d drop=%0d ready=%b required 0 0 0", accepted_cnt, dropped_cnt, in_ready); end
    exp_q.delete();
    @(negedge clk);
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL mid_held: got %b required 0", fifo_write_en); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || fifo_write_en !== 1'b0 || dropped_cnt !== 4'd0) begin errors++; $display("FAIL mid_release: got ready=%b en=%b drop=%0d required 1 0 0", in_ready, fifo_write_en, dropped_cnt); end
    $display("mid-operation reset done");
  endtask

  task automatic test_saturate;
    logic [CW-1:0] exp_drop;
    int            sum;
    exp_drop = '0;
    for (int k = 0; k < 9; k++) begin
      fifo_full = 1'b1; in_valid = 1'b1; in_data = 8'(8'h80 + 2 * k);
      @(negedge clk);
      in_data = 8'(8'h81 + 2 * k);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      sum = int'(exp_drop) + 2;
      exp_drop = (sum > 15) ? 4'hF : 4'(sum);
      checks++;
      if (dropped_cnt !== exp_drop) begin
        errors++;
        $display("FAIL sat_drop[%0d]: got %0d required %0d", k, dropped_cnt, exp_drop);
      end else begin
        $display("flush %0d dropped_cnt=%0d", k, dropped_cnt);
      end
      @(negedge clk);
    end
    fifo_full = 1'b0;
    checks++; if (accepted_cnt !== 4'd1) begin errors++; $display("FAIL sat_acc: got %0d required 1", accepted_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stream(8, 8'h11, 4'd8);
    test_full_skid();
    test_threshold();
    test_flush();
    test_reset_midop();
    test_stream(17, 8'h03, 4'd1);
    test_saturate();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d words pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
